// File: rtl/sramlike_icache_pkg.sv
// Shared types and address helpers for the sram-like instruction cache.
// Used by sramlike_icache and icache_store.
package sramlike_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    REFILL_DONE,
    UNC_REQ,
    UNC_WAIT
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Tag field, right-aligned.
  function automatic logic [31:0] addr_tag(
    input logic [31:0] a,
    input int          iw,
    input int          ow
  );
    return a >> (iw + ow);
  endfunction

  // Line index field, right-aligned.
  function automatic logic [31:0] addr_index(
    input logic [31:0] a,
    input int          iw,
    input int          ow
  );
    return (a >> ow) & ((32'd1 << iw) - 32'd1);
  endfunction

  // Word-in-line field; zero when a line holds one word.
  function automatic logic [31:0] addr_word(
    input logic [31:0] a,
    input int          ow
  );
    return (a >> 2) & ((32'd1 << (ow - 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/sramlike_icache_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One async read port, one sync write port, flash invalidate.
module icache_store
  import sramlike_cache_pkg::*;
#(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 4,
  parameter int TAG_W    = 32 - INDEX_W - OFFSET_W,
  parameter int CW       = (OFFSET_W > 2) ? OFFSET_W - 2 : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [CW-1:0]      rd_off,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               wr_data_en,
  input  logic [CW-1:0]      wr_off,
  input  logic [31:0]        wr_data,
  input  logic               wr_tag_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               flash_clr
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (OFFSET_W - 2);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

  // Valid bits: cleared by reset or flash invalidate, set on tag write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flash_clr) begin
      valid_q <= '0;
    end else if (wr_tag_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (wr_tag_en) begin
      tag_q[wr_idx] <= wr_tag;
    end
    if (wr_data_en) begin
      data_q[wr_idx][wr_off] <= wr_data;
    end
  end

endmodule

// File: rtl/sramlike_icache.sv
// Direct-mapped sram-like instruction cache: FSM and handshakes.
// Define ICACHE_PERF_CNT_EN to build the hit/miss counters.
module sramlike_icache
  import sramlike_cache_pkg::*;
#(
  parameter  int INDEX_W  = 6,
  parameter  int OFFSET_W = 4,
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic [31:0] cpu_inst_addr,
  input  logic        cpu_inst_uncached,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic [31:0] cpu_inst_rdata,
  input  logic        cache_inv,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WORDS = 1 << (OFFSET_W - 2);
  localparam int CW    = (OFFSET_W > 2) ? OFFSET_W - 2 : 1;

  state_t             state;
  state_t             nxt;
  logic [31:0]        req_addr;
  logic [CW-1:0]      cnt;
  logic               inv_pend;
  logic [31:0]        rdata_q;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [CW-1:0]      woff;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [31:0]        line_word;
  logic               hit;
  logic               last;
  logic               wr_data_en;
  logic               wr_tag_en;
  logic               flash_clr;

  assign idx  = INDEX_W'(addr_index(req_addr, INDEX_W, OFFSET_W));
  assign tag  = TAG_W'(addr_tag(req_addr, INDEX_W, OFFSET_W));
  assign woff = CW'(addr_word(req_addr, OFFSET_W));
  assign hit  = line_valid && (line_tag == tag);
  assign last = (cnt == CW'(WORDS - 1));

  assign mem_wr    = 1'b0;
  assign mem_size  = SIZE_WORD;
  assign mem_wdata = '0;

  icache_store #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TAG_W    (TAG_W),
    .CW       (CW)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (idx),
    .rd_off     (woff),
    .rd_valid   (line_valid),
    .rd_tag     (line_tag),
    .rd_data    (line_word),
    .wr_idx     (idx),
    .wr_data_en (wr_data_en),
    .wr_off     (cnt),
    .wr_data    (mem_rdata),
    .wr_tag_en  (wr_tag_en),
    .wr_tag     (tag),
    .flash_clr  (flash_clr)
  );

  // Next state, handshakes and storage write strobes.
  always_comb begin
    nxt              = state;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = rdata_q;
    mem_req          = 1'b0;
    mem_addr         = '0;
    wr_data_en       = 1'b0;
    wr_tag_en        = 1'b0;
    flash_clr        = 1'b0;
    unique case (state)
      IDLE: begin
        flash_clr = cache_inv || inv_pend;
        if (cpu_inst_req && !flash_clr && !rst) begin
          cpu_inst_addr_ok = 1'b1;
          nxt = cpu_inst_uncached ? UNC_REQ : LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = line_word;
          nxt = IDLE;
        end else begin
          nxt = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, OFFSET_W'(0)} | (32'(cnt) << 2);
        if (mem_addr_ok) nxt = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_data_ok) begin
          wr_data_en = 1'b1;
          nxt = last ? REFILL_DONE : MISS_REQ;
        end
      end
      REFILL_DONE: begin
        wr_tag_en        = 1'b1;
        cpu_inst_data_ok = 1'b1;
        cpu_inst_rdata   = line_word;
        nxt = IDLE;
      end
      UNC_REQ: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (mem_addr_ok) nxt = UNC_WAIT;
      end
      UNC_WAIT: begin
        if (mem_data_ok) begin
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = mem_rdata;
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, request latch, refill counter, pending invalidate, read hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= '0;
      cnt      <= '0;
      inv_pend <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= nxt;
      if (cpu_inst_addr_ok) req_addr <= cpu_inst_addr;
      if (state == LOOKUP) begin
        cnt <= '0;
      end else if (state == MISS_WAIT && mem_data_ok && !last) begin
        cnt <= cnt + 1'b1;
      end
      if (state == IDLE) begin
        inv_pend <= 1'b0;
      end else if (cache_inv) begin
        inv_pend <= 1'b1;
      end
      if (cpu_inst_data_ok) rdata_q <= cpu_inst_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Count lookup outcomes; uncached fetches never reach LOOKUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_q <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_sramlike_icache.sv
// Scoreboard bench for sramlike_icache: directed fetches,
// memory model, decoupled monitor for mem and cpu responses.
module tb_sramlike_icache;

  logic        clk;
  logic        rst;
  logic        cpu_inst_req;
  logic [31:0] cpu_inst_addr;
  logic        cpu_inst_uncached;
  logic        cpu_inst_addr_ok;
  logic        cpu_inst_data_ok;
  logic [31:0] cpu_inst_rdata;
  logic        cache_inv;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  sramlike_icache dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_inst_req      (cpu_inst_req),
    .cpu_inst_addr     (cpu_inst_addr),
    .cpu_inst_uncached (cpu_inst_uncached),
    .cpu_inst_addr_ok  (cpu_inst_addr_ok),
    .cpu_inst_data_ok  (cpu_inst_data_ok),
    .cpu_inst_rdata    (cpu_inst_rdata),
    .cache_inv         (cache_inv),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
    bit          unc;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] exp_a [$];
  logic [31:0] img [logic [31:0]];
  int          n_chk = 0;
  int          n_fail = 0;
  int          e_hit = 0;
  int          e_miss = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic logic [31:0] img_rd(input logic [31:0] a);
    if (img.exists(a)) return img[a];
    return 32'hDEAD_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory: accept immediately, return data the cycle after accept.
  initial begin
    logic        acc;
    logic [31:0] a_acc;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      acc   = mem_req && mem_addr_ok && !rst;
      a_acc = mem_addr;
      @(posedge clk);
      #1;
      mem_data_ok = acc;
      if (acc) mem_rdata = img_rd(a_acc);
      mem_addr_ok = mem_req;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response.
  initial begin
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (mem_req && mem_addr_ok) begin
          if (exp_a.size() == 0) begin
            chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
          end else begin
            chk("mem_addr", mem_addr, exp_a.pop_front());
            chk("mem_wr_size", {29'b0, mem_wr, mem_size}, 32'h2);
          end
        end
        if (cpu_inst_data_ok) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_data_ok", cpu_inst_rdata, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("cpu_rdata", cpu_inst_rdata, e.data);
            if (e.lat >= 0)
              chk("hit_latency", 32'(cyc - acc_cyc), 32'(e.lat));
            if (e.unc)
              chk("unc_same_cycle", {31'b0, mem_data_ok}, 32'd1);
          end
        end
        if (cpu_inst_addr_ok) acc_cyc = cyc;
      end
    end
  end

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_a.push_back(base + 32'(4 * i));
  endtask

  task automatic push_data(input logic [31:0] d, input int lat,
                           input bit unc);
    exp_t e;
    e.data = d;
    e.lat  = lat;
    e.unc  = unc;
    exp_q.push_back(e);
  endtask

  task automatic fetch_start(input logic [31:0] a, input logic u);
    bit ok = 0;
    @(posedge clk);
    #1;
    cache_inv         = 1'b0;
    cpu_inst_req      = 1'b1;
    cpu_inst_addr     = a;
    cpu_inst_uncached = u;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cpu_inst_addr_ok) ok = 1;
    end
    if (!ok) timeout("addr_ok");
    @(posedge clk);
    #1;
    cpu_inst_req = 1'b0;
  endtask

  task automatic fetch_wait(input string nm);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cpu_inst_data_ok) got = 1;
    end
    if (!got) timeout(nm);
  endtask

  task automatic chk_cnt(input string nm);
`ifdef ICACHE_PERF_CNT_EN
    chk({nm, "_hit_cnt"}, hit_cnt, 32'(e_hit));
    chk({nm, "_miss_cnt"}, miss_cnt, 32'(e_miss));
`else
    chk({nm, "_hit_cnt"}, hit_cnt, 32'd0);
    chk({nm, "_miss_cnt"}, miss_cnt, 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int nd;
    img[32'h1FC0_0000] = 32'hA0;
    img[32'h1FC0_0004] = 32'hA1;
    img[32'h1FC0_0008] = 32'hA2;
    img[32'h1FC0_000C] = 32'hA3;
    img[32'h1FC0_0400] = 32'hB0;
    img[32'h1FC0_0404] = 32'hB1;
    img[32'h1FC0_0408] = 32'hB2;
    img[32'h1FC0_040C] = 32'hB3;

    rst               = 1'b1;
    cpu_inst_req      = 1'b1;
    cpu_inst_addr     = 32'h1FC0_0000;
    cpu_inst_uncached = 1'b0;
    cache_inv         = 1'b0;
    @(negedge clk);
    chk("rst_addr_ok", {31'b0, cpu_inst_addr_ok}, 32'd0);
    chk("rst_data_ok", {31'b0, cpu_inst_data_ok}, 32'd0);
    chk("rst_rdata", cpu_inst_rdata, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk_cnt("rst");
    @(posedge clk);
    #1;
    cpu_inst_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    push_line(32'h1FC0_0000);
    push_data(32'hA0, -1, 0);
    fetch_start(32'h1FC0_0000, 1'b0);
    fetch_wait("cold_miss");
    e_miss++;
    chk_cnt("cold");

    push_data(32'hA2, 1, 0);
    fetch_start(32'h1FC0_0008, 1'b0);
    fetch_wait("hit");
    e_hit++;
    @(negedge clk);
    chk("rdata_hold", cpu_inst_rdata, 32'hA2);
    chk_cnt("hit");

    img[32'h1FC0_0004] = 32'hBEEF;
    exp_a.push_back(32'h1FC0_0004);
    push_data(32'hBEEF, -1, 1);
    fetch_start(32'h1FC0_0004, 1'b1);
    fetch_wait("uncached");
    chk_cnt("unc");

    push_data(32'hA1, 1, 0);
    fetch_start(32'h1FC0_0004, 1'b0);
    fetch_wait("line_untouched");
    e_hit++;
    img[32'h1FC0_0004] = 32'hA1;

    push_line(32'h1FC0_0400);
    push_data(32'hB0, -1, 0);
    fetch_start(32'h1FC0_0400, 1'b0);
    fetch_wait("conflict_miss");
    e_miss++;

    push_line(32'h1FC0_0000);
    push_data(32'hA0, -1, 0);
    fetch_start(32'h1FC0_0000, 1'b0);
    fetch_wait("evicted_miss");
    e_miss++;
    chk_cnt("conflict");

    push_line(32'h1FC0_0400);
    push_data(32'hB0, -1, 0);
    fetch_start(32'h1FC0_0400, 1'b0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr_ok) seen = 1;
    end
    if (!seen) timeout("inv_mem_accept");
    @(posedge clk);
    #1;
    cache_inv = 1'b1;
    @(posedge clk);
    #1;
    cache_inv = 1'b0;
    fetch_wait("inv_refill");
    e_miss++;
    @(posedge clk);
    #1;
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = 32'h1FC0_0400;
    @(negedge clk);
    chk("inv_pend_block", {31'b0, cpu_inst_addr_ok}, 32'd0);
    push_line(32'h1FC0_0400);
    push_data(32'hB0, -1, 0);
    fetch_start(32'h1FC0_0400, 1'b0);
    fetch_wait("after_inv_miss");
    e_miss++;

    @(posedge clk);
    #1;
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = 32'h1FC0_0400;
    cache_inv     = 1'b1;
    @(negedge clk);
    chk("inv_wins", {31'b0, cpu_inst_addr_ok}, 32'd0);
    push_line(32'h1FC0_0400);
    push_data(32'hB0, -1, 0);
    fetch_start(32'h1FC0_0400, 1'b0);
    fetch_wait("inv_req_miss");
    e_miss++;
    chk_cnt("inv");

    exp_a.push_back(32'h1FC0_0000);
    exp_a.push_back(32'h1FC0_0004);
    fetch_start(32'h1FC0_0000, 1'b0);
    nd = 0;
    for (int i = 0; i < 50 && nd < 2; i++) begin
      @(negedge clk);
      if (mem_data_ok) nd++;
    end
    if (nd < 2) timeout("rst_refill_words");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_data_ok", {31'b0, cpu_inst_data_ok}, 32'd0);
    e_hit  = 0;
    e_miss = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_line(32'h1FC0_0000);
    push_data(32'hA0, -1, 0);
    fetch_start(32'h1FC0_0000, 1'b0);
    fetch_wait("post_rst_miss");
    e_miss++;
    chk_cnt("post_rst");

    repeat (3) @(negedge clk);
    chk("exp_addr_left", 32'(exp_a.size()), 32'd0);
    chk("exp_data_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sramlike_icache.md
Name: sramlike_icache

Overview:
- Parametrised direct-mapped instruction cache. Replaces the pass-through dummy cache between the instruction sram-like converter and cpu_axi_interface.
- CPU side: read-only sram-like slave. Memory side: single-word sram-like master.
- Refills whole lines one word at a time. Bypasses storage for uncached fetches. Supports full invalidation.

Parameters:
- INDEX_W, 6, index bits; number of lines is 2**INDEX_W.
- OFFSET_W, 4, byte-offset bits; words per line WORDS = 2**(OFFSET_W-2), minimum OFFSET_W=2.
- TAG_W, 32-INDEX_W-OFFSET_W, tag width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_inst_req  in  1  fetch request.
- cpu_inst_addr  in  32  physical fetch address, word aligned.
- cpu_inst_uncached  in  1  sampled with the request; 1 = bypass cache.
- cpu_inst_addr_ok  out  1  request accepted.
- cpu_inst_data_ok  out  1  cpu_inst_rdata valid this cycle.
- cpu_inst_rdata  out  32  instruction word.
- cache_inv  in  1  pulse; invalidate all lines.
- mem_req  out  1  memory read request.
- mem_wr  out  1  always 0.
- mem_size  out  2  always 2'b10 (word).
- mem_addr  out  32  word address.
- mem_wdata  out  32  always 0.
- mem_rdata  in  32  returned word.
- mem_addr_ok  in  1  memory accepted mem_req.
- mem_data_ok  in  1  mem_rdata valid.
- hit_cnt  out  32  hit counter (see Optional Feature).
- miss_cnt  out  32  miss counter (see Optional Feature).

Behaviour:
- Reset (async, while rst=1): state IDLE; all valid bits 0; refill counter 0; pending invalidate 0; cpu_inst_addr_ok=0, cpu_inst_data_ok=0, cpu_inst_rdata=0; mem_req=0, mem_addr=0. Tag/data arrays are not reset.
- One outstanding CPU request at a time. cpu_inst_addr_ok = cpu_inst_req in IDLE with no pending invalidate, otherwise 0. On accept, address and uncached flag are latched.
- IDLE -> LOOKUP on accept of a cached request. IDLE -> UNC_REQ on accept of an uncached request.
- LOOKUP, hit (valid & tag match):
  - cpu_inst_data_ok=1 with the indexed word; -> IDLE.
  - Hit latency: data_ok exactly 1 cycle after addr_ok; peak throughput one fetch per 2 cycles.
- LOOKUP, miss: refill counter := 0; -> MISS_REQ.
- MISS_REQ:
  - mem_req=1, mem_addr={tag,index,counter,2'b00}; held stable until mem_addr_ok.
  - On mem_addr_ok -> MISS_WAIT.
- MISS_WAIT:
  - On mem_data_ok: write mem_rdata into line word[counter].
  - If counter==WORDS-1 -> REFILL_DONE; else counter++ and -> MISS_REQ.
- REFILL_DONE:
  - Write tag, set valid.
  - cpu_inst_data_ok=1 with the requested word, taken from the just-written line; -> IDLE.
- UNC_REQ: mem_req=1, mem_addr=latched address; on mem_addr_ok -> UNC_WAIT.
- UNC_WAIT:
  - cpu_inst_data_ok=mem_data_ok and cpu_inst_rdata=mem_rdata, combinational passthrough; -> IDLE on mem_data_ok.
  - Cache contents are untouched.
- Only one memory request is in flight; mem_req is never asserted in MISS_WAIT, UNC_WAIT or IDLE.
- cpu_inst_rdata holds its last value when data_ok=0.
- cache_inv:
  - In IDLE with no request accepted: clear all valid bits next edge.
  - Otherwise set pending; the clear happens on the first IDLE cycle, and addr_ok is blocked that cycle.
  - A refill in progress completes and returns its data, then is invalidated.
- Simultaneous cache_inv and cpu_inst_req in IDLE: invalidate wins; the request is accepted next cycle and misses.
- mem_data_ok outside MISS_WAIT/UNC_WAIT is ignored.
- Reset mid-refill: abort immediately; the partial line stays invalid.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: hit_cnt increments on every LOOKUP hit; miss_cnt increments on every LOOKUP miss. Both are 32-bit, wrap 0xFFFFFFFF->0, reset to 0. Uncached fetches count neither.
- Undefined: hit_cnt and miss_cnt tied to 0; no counter registers.

Decomposition:
- Package sramlike_cache_pkg:
  - state enum (IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL_DONE, UNC_REQ, UNC_WAIT);
  - constant SIZE_WORD=2'b10;
  - address-field slicing helpers parameterised by INDEX_W/OFFSET_W.
- Sub-module icache_store:
  - valid/tag/data arrays, one read port and one write port;
  - async valid clear on rst, synchronous flash invalidate.
- Top: FSM and handshakes only.

Test Plan:
- Cold fetch 0x1FC00000 (cached, defaults), memory returns 0xA0,0xA1,0xA2,0xA3 -> four mem requests at 0x1FC00000/04/08/0C, cpu data_ok with 0xA0; miss_cnt=1.
- Subsequent fetch 0x1FC00008 -> no mem_req, data_ok 1 cycle after addr_ok with 0xA2; hit_cnt=1.
- Uncached fetch 0x1FC00004 with memory returning 0xBEEF -> single mem_req at 0x1FC00004, data_ok same cycle as mem_data_ok with 0xBEEF; line still holds 0xA1; counters unchanged.
- Fetch 0x1FC00400 (same index, different tag) -> miss, refill; refetch 0x1FC00000 -> miss again.
- cache_inv during MISS_WAIT -> refill completes, data returned, addr_ok low one IDLE cycle; next fetch of that line misses.
- rst asserted after second refill word -> mem_req=0 and data_ok=0 immediately; after release, same fetch misses and issues 4 requests.
